// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit.
// Multiply takes one MUL cycle; divide is a restoring shift-subtract followed by a sign fix-up.
module muldiv_unit #(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   quo_q, quo_d, div_q, div_d, rem_q, rem_d, result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sa_q, sa_d, sb_q, sb_d, zero_q, zero_d;
    logic              accept, neg1, neg2, div_zero, ovf;
    logic [XLEN-1:0]   spec_res, mul_res, quo_fix, rem_fix;
    logic [2*XLEN-1:0] ext1, ext2, prod;
    logic [XLEN:0]     shifted, diff;
    assign ready    = state_q == S_IDLE;
    assign busy     = ~ready;
    assign done     = state_q == S_DONE;
    assign result   = result_q;
    assign zero     = zero_q;
    assign accept   = start && ready && !flush;
    assign neg1     = op[2] & ~op[0] & operand1[XLEN-1];
    assign neg2     = op[2] & ~op[0] & operand2[XLEN-1];
    assign div_zero = operand2 == '0;
    assign ovf      = ~op[0] && operand1 == MIN_INT && operand2 == '1;
    assign spec_res = div_zero ? (op[1] ? operand1 : '1) : (op[1] ? '0 : MIN_INT);
    // Operands are widened to 2*XLEN first so the wrapped product is exact for every sign mix
    assign ext1     = {{XLEN{(op_q[1] ^ op_q[0]) & quo_q[XLEN-1]}}, quo_q};
    assign ext2     = {{XLEN{~op_q[1] & op_q[0] & div_q[XLEN-1]}}, div_q};
    assign prod     = ext1 * ext2;
    assign mul_res  = op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign diff     = shifted - {1'b0, div_q};
    assign quo_fix  = (sa_q ^ sb_q) ? -quo_q : quo_q;
    assign rem_fix  = sa_q ? -rem_q : rem_q;
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        quo_d    = quo_q;
        div_d    = div_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d  = op;
                sa_d  = neg1;
                sb_d  = neg2;
                quo_d = neg1 ? -operand1 : operand1;
                div_d = neg2 ? -operand2 : operand2;
                rem_d = '0;
                if (!op[2]) state_d = S_MUL;
                else if (div_zero || ovf) begin
                    state_d  = S_DONE;
                    result_d = spec_res;
                end else begin
                    state_d = S_DIV;
                    cnt_d   = CNT_W'(XLEN - 1);
                end
            end
            S_MUL: begin
                result_d = mul_res;
                state_d  = S_DONE;
            end
            S_DIV: begin
                quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN]};
                rem_d   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = cnt_q == '0 ? S_FIX : S_DIV;
            end
            S_FIX: begin
                result_d = op_q[1] ? rem_fix : quo_fix;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush && (state_q == S_MUL || state_q == S_DIV || state_q == S_FIX)) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
        zero_d = result_d == '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit at XLEN=32 and XLEN=16.
module tb_muldiv_unit;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0, total = 0, bad = 0;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct { logic [31:0] res; int due; } exp_t;
    exp_t q32[$], q16[$];
    logic        start32 = 1'b0, flush32 = 1'b0, ready32, busy32, done32, zero32;
    logic [2:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0, result32;
    logic        start16 = 1'b0, ready16, busy16, done16, zero16;
    logic [2:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0, result16;
    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .operand1(a32), .operand2(b32),
        .flush(flush32), .ready(ready32), .busy(busy32), .done(done32), .result(result32), .zero(zero32)
    );
    muldiv_unit #(.XLEN(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .operand1(a16), .operand2(b16),
        .flush(1'b0), .ready(ready16), .busy(busy16), .done(done16), .result(result16), .zero(zero16)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask
    // Reference: RV32M semantics in plain 64-bit integer arithmetic, for any width w <= 32
    function automatic logic [31:0] model(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint m  = (longint'(1) << w) - 1;
        longint ua = longint'(a) & m;
        longint ub = longint'(b) & m;
        longint sa = a[w-1] ? ua - (longint'(1) << w) : ua;
        longint sb = b[w-1] ? ub - (longint'(1) << w) : ub;
        longint mn = longint'(1) << (w - 1);
        logic [63:0] p;
        longint r;
        case (op)
            3'd0: r = sa * sb;
            3'd1: begin p = sa * sb; r = longint'(p >> w); end
            3'd2: begin p = sa * ub; r = longint'(p >> w); end
            3'd3: begin p = ua * ub; r = longint'(p >> w); end
            3'd4: r = ub == 0 ? m : (ua == mn && ub == m) ? mn : sa / sb;
            3'd5: r = ub == 0 ? m : ua / ub;
            3'd6: r = ub == 0 ? ua : (ua == mn && ub == m) ? 0 : sa % sb;
            default: r = ub == 0 ? ua : ua % ub;
        endcase
        return 32'(r & m);
    endfunction
    function automatic int latency(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint m  = (longint'(1) << w) - 1;
        longint ua = longint'(a) & m;
        longint ub = longint'(b) & m;
        if (!op[2]) return 2;
        if (ub == 0 || (!op[0] && ua == (longint'(1) << (w - 1)) && ub == m)) return 1;
        return w + 2;
    endfunction
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_8000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction
    task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
        int n = 0;
        exp_t e;
        while (!ready32) begin
            @(posedge clk); #1;
            if (++n > 100) begin check("ready_timeout32", 32'(ready32), 32'd1); return; end
        end
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(posedge clk); #1;
        start32 = 1'b0;
        e.res = want;
        e.due = cyc + latency(32, op, a, b) - 1;
        q32.push_back(e);
    endtask
    task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [31:0] want);
        int n = 0;
        exp_t e;
        while (!ready16) begin
            @(posedge clk); #1;
            if (++n > 100) begin check("ready_timeout16", 32'(ready16), 32'd1); return; end
        end
        start16 = 1'b1; op16 = op; a16 = a; b16 = b;
        @(posedge clk); #1;
        start16 = 1'b0;
        e.res = want;
        e.due = cyc + latency(16, op, 32'(a), 32'(b)) - 1;
        q16.push_back(e);
    endtask
    task automatic drain();
        int n = 0;
        while (q32.size() != 0 || q16.size() != 0) begin
            @(posedge clk); #1;
            if (++n > 200) begin
                check("drain_timeout", 32'(q32.size() + q16.size()), 32'd0);
                q32.delete(); q16.delete();
                return;
            end
        end
        @(posedge clk); #1;
    endtask
    always @(negedge clk) if (rst_n) begin
        if (q32.size() != 0) check("busy_while_pending32", 32'({ready32, busy32}), 32'b01);
        if (done32) begin
            if (q32.size() == 0) check("unexpected_done32", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q32.pop_front();
                check("result32", result32, e.res);
                check("zero32", 32'(zero32), 32'(e.res == 0));
                check("done_cycle32", 32'(cyc), 32'(e.due));
            end
        end
    end
    always @(negedge clk) if (rst_n) begin
        if (q16.size() != 0) check("busy_while_pending16", 32'({ready16, busy16}), 32'b01);
        if (done16) begin
            if (q16.size() == 0) check("unexpected_done16", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q16.pop_front();
                check("result16", 32'(result16), e.res);
                check("zero16", 32'(zero16), 32'(e.res == 0));
                check("done_cycle16", 32'(cyc), 32'(e.due));
            end
        end
    end
    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ready32), 32'd1);
        check("reset_busy", 32'(busy32), 32'd0);
        check("reset_done", 32'(done32), 32'd0);
        check("reset_result", result32, 32'd0);
        check("reset_zero", 32'(zero32), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue32(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB); drain();
        issue32(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); drain();
        issue32(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); drain();
        issue32(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); drain();
        issue32(3'd0, 32'd0, 32'd5, 32'd0); drain();
        issue32(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD); drain();
        issue32(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF); drain();
        issue32(3'd5, 32'd100, 32'd7, 32'd14); drain();
        issue32(3'd7, 32'd100, 32'd7, 32'd2); drain();
        issue32(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF); drain();
        issue32(3'd6, 32'd5, 32'd0, 32'd5); drain();
        issue32(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); drain();
        issue32(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0); drain();
        issue32(3'd0, 32'd3, 32'd4, 32'd12); drain();
        start32 = 1'b1; flush32 = 1'b1; op32 = 3'd0; a32 = 32'd9; b32 = 32'd9;
        @(posedge clk); #1;
        start32 = 1'b0; flush32 = 1'b0;
        check("flush_beats_start", 32'(ready32), 32'd1);
        issue32(3'd4, 32'd1000, 32'd7, 32'd142);
        repeat (4) @(posedge clk);
        #1;
        start32 = 1'b1; op32 = 3'd0; a32 = 32'd9; b32 = 32'd9;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush32 = 1'b1;
        @(posedge clk); #1;
        flush32 = 1'b0;
        q32.delete();
        check("flush_ready", 32'(ready32), 32'd1);
        check("flush_result_kept", result32, 32'd12);
        issue32(3'd0, 32'd3, 32'd4, 32'd12); drain();
        issue32(3'd5, 32'd1000, 32'd3, 32'd333);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q32.delete();
        check("midop_reset_ready", 32'(ready32), 32'd1);
        check("midop_reset_done", 32'(done32), 32'd0);
        check("midop_reset_result", result32, 32'd0);
        check("midop_reset_zero", 32'(zero32), 32'd1);
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            issue32(rop, ra, rb, model(32, rop, ra, rb));
        end
        drain();
        issue16(3'd4, 16'h8000, 16'hFFFF, 32'h8000); drain();
        issue16(3'd5, 16'hFFFF, 16'h0010, 32'h0FFF); drain();
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            issue16(rop, ra[15:0], rb[15:0], model(16, rop, ra, rb));
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
